// File: rtl/sc_regserializer.sv
// sc_regserializer: captures the general register one cycle after its load command and sends it as start/MSB-first data/stop frame.
// Define SC_REGSERIALIZER_PARITY_EN to insert an even-parity bit between the data and stop bits.
module sc_regserializer #(
    parameter int DATAWIDTH = 8,
    parameter int BITCYCLES = 4
) (
    input  logic                 SC_REGSERIALIZER_CLOCK_50,
    input  logic                 SC_REGSERIALIZER_RESET_InLow,
    input  logic                 SC_REGSERIALIZER_load_InLow,
    input  logic [DATAWIDTH-1:0] SC_REGSERIALIZER_data_InBUS,
    output logic                 SC_REGSERIALIZER_serial_Out,
    output logic                 SC_REGSERIALIZER_busy_Out,
    output logic                 SC_REGSERIALIZER_done_OutLow,
    output logic                 SC_REGSERIALIZER_overrun_Out
);
    localparam int CW = BITCYCLES > 1 ? $clog2(BITCYCLES) : 1;
    localparam int BW = DATAWIDTH > 1 ? $clog2(DATAWIDTH) : 1;
    localparam logic [CW-1:0] CMAX = CW'(BITCYCLES - 1);
    localparam logic [BW-1:0] BMAX = BW'(DATAWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, ARM, START, DATA,
`ifdef SC_REGSERIALIZER_PARITY_EN
        PARITY,
`endif
        STOP, END
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bitc, bit_n;
    logic [DATAWIDTH-1:0] sh, sh_n;
    logic                 serial, serial_n, busy, busy_n, done, done_n, overrun, over_n;
    logic                 load, wrap;

    assign load = SC_REGSERIALIZER_load_InLow;
    assign wrap = cnt == CMAX;

`ifdef SC_REGSERIALIZER_PARITY_EN
    logic par, par_n;

    always_ff @(posedge SC_REGSERIALIZER_CLOCK_50) begin
        par <= !SC_REGSERIALIZER_RESET_InLow ? 1'b0 : par_n;
    end
`endif

    always_ff @(posedge SC_REGSERIALIZER_CLOCK_50) begin
        if (!SC_REGSERIALIZER_RESET_InLow) begin
            state   <= IDLE;
            cnt     <= '0;
            bitc    <= '0;
            sh      <= '0;
            serial  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bitc    <= bit_n;
            sh      <= sh_n;
            serial  <= serial_n;
            busy    <= busy_n;
            done    <= done_n;
            overrun <= over_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = (state inside {IDLE, ARM, END}) || wrap ? '0 : cnt + 1'b1;
        bit_n    = bitc;
        sh_n     = sh;
        serial_n = serial;
        busy_n   = busy;
        done_n   = 1'b1;
        // a command seen while a frame is in flight is dropped, only flagged
        over_n   = overrun | (!load && state != IDLE);
`ifdef SC_REGSERIALIZER_PARITY_EN
        par_n    = par;
`endif
        case (state)
            IDLE: begin
                state_n = load ? IDLE : ARM;
                busy_n  = !load;
            end
            ARM: begin
                state_n  = START;
                sh_n     = SC_REGSERIALIZER_data_InBUS;
                serial_n = 1'b0;
                bit_n    = '0;
`ifdef SC_REGSERIALIZER_PARITY_EN
                par_n    = ^SC_REGSERIALIZER_data_InBUS;
`endif
            end
            START: if (wrap) begin
                state_n  = DATA;
                serial_n = sh[DATAWIDTH-1];
                sh_n     = sh << 1;
            end
            DATA: if (wrap && bitc == BMAX) begin
`ifdef SC_REGSERIALIZER_PARITY_EN
                state_n  = PARITY;
                serial_n = par;
`else
                state_n  = STOP;
                serial_n = 1'b1;
`endif
            end else if (wrap) begin
                bit_n    = bitc + 1'b1;
                serial_n = sh[DATAWIDTH-1];
                sh_n     = sh << 1;
            end
`ifdef SC_REGSERIALIZER_PARITY_EN
            PARITY: if (wrap) begin
                state_n  = STOP;
                serial_n = 1'b1;
            end
`endif
            STOP: if (wrap) begin
                state_n = END;
                busy_n  = 1'b0;
                done_n  = 1'b0;
            end
            END: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign SC_REGSERIALIZER_serial_Out  = serial;
    assign SC_REGSERIALIZER_busy_Out    = busy;
    assign SC_REGSERIALIZER_done_OutLow = done;
    assign SC_REGSERIALIZER_overrun_Out = overrun;
endmodule

// File: doc/sc_regserializer.md
Name: sc_regserializer

Overview:
- Reader/transmitter end of the general-register load path.
- Watches the same active-low load command that the state machine sends to the general register, then captures the updated register output bus one cycle later.
- Transmits the captured word as a framed serial stream: start bit, data MSB-first, stop bit. Idle line is high.
- Reports busy, end-of-frame and overrun status to the rest of the system.

Parameters:
- DATAWIDTH, 8, width of the captured register bus and the number of data bits per frame (≥1).
- BITCYCLES, 4, clock cycles per serial bit period (≥1).

Ports:
- SC_REGSERIALIZER_CLOCK_50  in  1  system clock; all logic on the rising edge.
- SC_REGSERIALIZER_RESET_InLow  in  1  reset; synchronous, active-low.
- SC_REGSERIALIZER_load_InLow  in  1  active-low load command, the same signal that drives the general register's load input.
- SC_REGSERIALIZER_data_InBUS  in  DATAWIDTH  general register output bus.
- SC_REGSERIALIZER_serial_Out  out  1  registered serial line; high when idle.
- SC_REGSERIALIZER_busy_Out  out  1  high from command acceptance until frame end.
- SC_REGSERIALIZER_done_OutLow  out  1  one-cycle low pulse at frame end.
- SC_REGSERIALIZER_overrun_Out  out  1  sticky flag: a load command arrived while busy.

Behaviour:
- Reset (RESET_InLow=0 sampled at an edge, any state): state=IDLE, serial_Out=1, busy_Out=0, done_OutLow=1, overrun_Out=0, shift register=0, counters=0. Reset is not applied between edges.
- States: IDLE, ARM, START, DATA, STOP, END.
- IDLE:
  - serial=1, busy=0.
  - load_InLow=0 sampled at edge E0 -> ARM, busy=1 from E0.
- ARM:
  - Lasts exactly one cycle; lets the register complete its own load at E0.
  - At E1: shift register <= data_InBUS, serial=0, enter START.
- START: serial=0 for BITCYCLES cycles.
- DATA:
  - DATAWIDTH bit periods of BITCYCLES cycles each, MSB first (bit DATAWIDTH-1 first).
  - Shift register shifts left at each bit boundary.
- STOP: serial=1 for BITCYCLES cycles.
- END:
  - One cycle with done_OutLow=0 and busy=0, then IDLE.
  - busy falls at the same edge that done asserts, which is E1+(DATAWIDTH+2)*BITCYCLES.
- Counters:
  - Cycle counter runs 0..BITCYCLES-1 and wraps at each bit boundary.
  - Bit counter runs 0..DATAWIDTH-1, width clog2(DATAWIDTH), minimum 1.
  - BITCYCLES=1 must work: one cycle per bit, no idle gaps inside a frame.
- Overrun:
  - Any edge in ARM/START/DATA/STOP/END that samples load_InLow=0 sets overrun_Out=1.
  - The frame in progress is unaffected, and the command is dropped, not queued.
  - overrun_Out clears only on reset.
- Load held low continuously:
  - Overrun sets during the frame.
  - After END, the IDLE-cycle sample starts a new frame.
  - Minimum line-high gap between one frame's stop bit and the next start bit = BITCYCLES (stop) + 1 (END) + 1 (IDLE) + 1 (ARM).
- data_InBUS is sampled only at the ARM->START edge; later bus changes do not affect the frame.
- Reset mid-frame: the line returns high at the next edge, no done pulse, and the frame is lost.

Optional Feature:
- Macro SC_REGSERIALIZER_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting BITCYCLES cycles.
  - serial = XOR of the captured word (even parity).
  - Frame = (DATAWIDTH+3)*BITCYCLES cycles; done edge moves to E1+(DATAWIDTH+3)*BITCYCLES.
- Undefined: no parity state or logic; frame as described above.

Test Plan:
- Reset: drive RESET_InLow=0 for 2 edges mid-idle -> serial=1, busy=0, done_OutLow=1, overrun=0; toggling reset between edges produces no output change.
- Single frame (DATAWIDTH=8, BITCYCLES=4):
  - Stimulus: data_InBUS=0xA5, load_InLow low for one cycle at E0.
  - Expect busy=1 from E0, serial=0 at E1..E1+3.
  - Expect bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Expect serial=1 for 4 cycles, then done_OutLow=0 for exactly one cycle with busy=0 at E1+40.
- Bus stability: change data_InBUS to 0x3C one cycle after E1 -> transmitted bits still 0xA5.
- Overrun: second load strobe during the DATA state of the 0xA5 frame -> overrun=1 from the next edge, frame bits unchanged, no second frame; remains 1 until reset.
- Back-to-back: hold load_InLow=0 -> two consecutive frames separated by a 7-cycle high gap (BITCYCLES=4); overrun=1.
- Mid-frame reset: assert reset during DATA bit 3 -> at the next edge serial=1, busy=0, no done pulse. PARITY_EN build: 0xA5 -> parity bit 0, 0x07 -> parity bit 1, done at E1+44.
